// File: rtl/rom_arb_pkg.sv
// Shared types for the DDR3 ROM port arbiter.
// Requester ids, FSM states and the latched downstream command.
package rom_arb_pkg;

    localparam int ARB_ADDR_W = 24;

    typedef enum logic [1:0] {
        REQ_LD,
        REQ_CPU,
        REQ_SV
    } req_id_t;

    typedef enum logic {
        IDLE,
        WAIT
    } arb_state_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic                  we;
        logic [1:0]            be;
        logic [15:0]           din;
    } mem_cmd_t;

endpackage

// File: rtl/rom_port_arbiter_toggle_slot.sv
// One requester side of a toggle handshake: pending flag,
// ack toggle on completion and optional read-data capture.
module toggle_slot (
    input  logic        MCLK,
    input  logic        RESET_N,
    input  logic        req,
    input  logic        done,
    input  logic        cap,
    input  logic [15:0] din,
    output logic        ack,
    output logic        pending,
    output logic [15:0] dout
);

    assign pending = req != ack;

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ack  <= 1'b0;
            dout <= '0;
        end else if (done) begin
            ack <= ~ack;
            if (cap) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the toggle-handshake DDR3 ROM port between the loader,
// the 68k ROM fetch and the save-RAM backup engine.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int STARVE_MAX = 4
) (
    input  logic              MCLK,
    input  logic              RESET_N,
    input  logic              LOADING,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [15:0]       ld_din,
    input  logic              ld_req,
    output logic              ld_ack,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [15:0]       cpu_dout,
    input  logic              cpu_req,
    output logic              cpu_ack,
    input  logic [ADDR_W-1:0] sv_addr,
    input  logic              sv_we,
    input  logic [1:0]        sv_be,
    input  logic [15:0]       sv_din,
    output logic [15:0]       sv_dout,
    input  logic              sv_req,
    output logic              sv_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    output logic [15:0]       mem_din,
    input  logic [15:0]       mem_dout,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic              busy
);

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    arb_state_t  state_q, state_d;
    req_id_t     gnt_q, gnt_d;
    mem_cmd_t    cmd_q, cmd_d;
    logic        mem_req_q;
    logic [2:0]  starve_q, starve_d;

    logic        ld_p, cpu_p, sv_p;
    logic        ld_win, cpu_win, sv_win, grant;
    logic        ack_in, cap;
    logic        ld_done, cpu_done, sv_done;
    logic [15:0] ld_dout_unused;

    assign ack_in   = (state_q == WAIT) && (mem_ack == mem_req_q);
    assign cap      = ~cmd_q.we;
    assign ld_done  = ack_in && (gnt_q == REQ_LD);
    assign cpu_done = ack_in && (gnt_q == REQ_CPU);
    assign sv_done  = ack_in && (gnt_q == REQ_SV);

    toggle_slot u_ld (
        .MCLK    (MCLK),
        .RESET_N (RESET_N),
        .req     (ld_req),
        .done    (ld_done),
        .cap     (cap),
        .din     (mem_dout),
        .ack     (ld_ack),
        .pending (ld_p),
        .dout    (ld_dout_unused)
    );

    toggle_slot u_cpu (
        .MCLK    (MCLK),
        .RESET_N (RESET_N),
        .req     (cpu_req),
        .done    (cpu_done),
        .cap     (cap),
        .din     (mem_dout),
        .ack     (cpu_ack),
        .pending (cpu_p),
        .dout    (cpu_dout)
    );

    toggle_slot u_sv (
        .MCLK    (MCLK),
        .RESET_N (RESET_N),
        .req     (sv_req),
        .done    (sv_done),
        .cap     (cap),
        .din     (mem_dout),
        .ack     (sv_ack),
        .pending (sv_p),
        .dout    (sv_dout)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        cmd_d    = cmd_q;
        starve_d = starve_q;
        ld_win   = 1'b0;
        cpu_win  = 1'b0;
        sv_win   = 1'b0;

        // During download only the loader may reach the port.
        if (state_q == IDLE) begin
            if (ld_p) begin
                ld_win = 1'b1;
            end else if (!LOADING) begin
                if (sv_p && (!cpu_p || starve_q == STARVE_LIM)) begin
                    sv_win = 1'b1;
                end else if (cpu_p) begin
                    cpu_win = 1'b1;
                end
            end
        end
        grant = ld_win | cpu_win | sv_win;

        unique case (1'b1)
            ld_win: begin
                gnt_d      = REQ_LD;
                cmd_d.addr = ARB_ADDR_W'(ld_addr);
                cmd_d.we   = 1'b1;
                cmd_d.be   = 2'b11;
                cmd_d.din  = ld_din;
            end
            cpu_win: begin
                gnt_d      = REQ_CPU;
                cmd_d.addr = ARB_ADDR_W'(cpu_addr);
                cmd_d.we   = 1'b0;
                cmd_d.be   = 2'b11;
                cmd_d.din  = '0;
            end
            sv_win: begin
                gnt_d      = REQ_SV;
                cmd_d.addr = ARB_ADDR_W'(sv_addr);
                cmd_d.we   = sv_we;
                cmd_d.be   = sv_we ? sv_be : 2'b11;
                cmd_d.din  = sv_din;
            end
            default: ;
        endcase

        if (grant) begin
            state_d = WAIT;
        end else if (ack_in) begin
            state_d = IDLE;
        end

        // Save gets a turn after STARVE_MAX CPU grants in a row.
        if (!sv_p || sv_win) begin
            starve_d = '0;
        end else if (cpu_win && starve_q != STARVE_LIM) begin
            starve_d = starve_q + 3'd1;
        end
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            gnt_q     <= REQ_LD;
            cmd_q     <= '0;
            mem_req_q <= 1'b0;
            starve_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            cmd_q    <= cmd_d;
            starve_q <= starve_d;
            if (grant) begin
                mem_req_q <= ~mem_req_q;
            end
        end
    end

    assign mem_addr = ADDR_W'(cmd_q.addr);
    assign mem_we   = cmd_q.we;
    assign mem_be   = cmd_q.be;
    assign mem_din  = cmd_q.din;
    assign mem_req  = mem_req_q;
    assign busy     = state_q == WAIT;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter with a toggle-protocol
// memory model and directed transactions.
module tb_rom_port_arbiter;

    logic        MCLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic        LOADING = 1'b0;
    logic [23:0] ld_addr = '0, cpu_addr = '0, sv_addr = '0;
    logic [15:0] ld_din = '0, sv_din = '0, mem_dout = '0;
    logic        ld_req = 1'b0, cpu_req = 1'b0, sv_req = 1'b0;
    logic        sv_we = 1'b0, mem_ack = 1'b0;
    logic [1:0]  sv_be = '0;

    logic        ld_ack, cpu_ack, sv_ack, mem_req, mem_we, busy;
    logic [15:0] cpu_dout, sv_dout, mem_din;
    logic [23:0] mem_addr;
    logic [1:0]  mem_be;

    rom_port_arbiter #(.ADDR_W(24), .STARVE_MAX(4)) dut (
        .MCLK     (MCLK),
        .RESET_N  (RESET_N),
        .LOADING  (LOADING),
        .ld_addr  (ld_addr),
        .ld_din   (ld_din),
        .ld_req   (ld_req),
        .ld_ack   (ld_ack),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_req  (cpu_req),
        .cpu_ack  (cpu_ack),
        .sv_addr  (sv_addr),
        .sv_we    (sv_we),
        .sv_be    (sv_be),
        .sv_din   (sv_din),
        .sv_dout  (sv_dout),
        .sv_req   (sv_req),
        .sv_ack   (sv_ack),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_req  (mem_req),
        .mem_ack  (mem_ack),
        .busy     (busy)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        logic [23:0] addr;
        logic        we;
        logic [1:0]  be;
        logic [15:0] din;
    } gexp_t;

    gexp_t       gq[$];
    logic [15:0] cq[$];
    logic [15:0] sq[$];
    logic [15:0] rom [int];

    int n_vec = 0, n_err = 0;
    int cyc = 0, ack_cyc = 0, lat = 5, rst_epoch = 0;
    int grant_cyc = 0, cpu_done_cyc = 0;

    initial forever begin
        @(posedge MCLK);
        cyc++;
    end

    task automatic push_g(input logic [23:0] a, input logic w,
                          input logic [1:0] b, input logic [15:0] d);
        gexp_t e;
        e.addr = a; e.we = w; e.be = b; e.din = d;
        gq.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic wait_done(input int who);
        int   n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(negedge MCLK);
            n++;
            case (who)
                0:       done = ld_ack == ld_req;
                1:       done = cpu_ack == cpu_req;
                default: done = sv_ack == sv_req;
            endcase
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL ack_timeout who=%0d after %0d cycles", who, n);
        end
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_flags"}, {26'd0, cpu_ack, ld_ack, sv_ack, mem_req, mem_we, busy}, 32'd0);
        chk({tag, "_mem_be"}, {30'd0, mem_be}, 32'd0);
        chk({tag, "_mem_addr"}, {8'd0, mem_addr}, 32'd0);
        chk({tag, "_mem_din"}, {16'd0, mem_din}, 32'd0);
        chk({tag, "_cpu_dout"}, {16'd0, cpu_dout}, 32'd0);
        chk({tag, "_sv_dout"}, {16'd0, sv_dout}, 32'd0);
    endtask

    // Downstream memory: acks lat cycles after a new request.
    initial begin : mem_model
        logic [23:0] a;
        logic        w;
        logic [1:0]  b;
        logic [15:0] d, t;
        int          ep;
        forever begin
            @(negedge MCLK);
            if (RESET_N && mem_req != mem_ack) begin
                ep = rst_epoch;
                a = mem_addr; w = mem_we; b = mem_be; d = mem_din;
                for (int i = 1; i < lat; i++) begin
                    @(negedge MCLK);
                    if (ep != rst_epoch) break;
                end
                if (ep == rst_epoch) begin
                    t = rom.exists(int'(a)) ? rom[int'(a)] : 16'hDEAD;
                    if (w) begin
                        if (b[1]) t[15:8] = d[15:8];
                        if (b[0]) t[7:0] = d[7:0];
                        rom[int'(a)] = t;
                    end else begin
                        mem_dout = t;
                    end
                    mem_ack = ~mem_ack;
                    ack_cyc = cyc;
                end
            end
        end
    end

    initial begin : grant_mon
        logic  prev;
        gexp_t e;
        prev = 1'b0;
        forever begin
            @(negedge MCLK);
            if (!RESET_N) begin
                prev = mem_req;
            end else if (mem_req != prev) begin
                prev = mem_req;
                grant_cyc = cyc;
                n_vec++;
                if (gq.size() == 0) begin
                    n_err++;
                    $display("FAIL grant_unexpected addr=%h we=%b be=%b", mem_addr, mem_we, mem_be);
                end else begin
                    e = gq.pop_front();
                    if (mem_addr !== e.addr || mem_we !== e.we || mem_be !== e.be ||
                        (e.we && mem_din !== e.din) || busy !== 1'b1) begin
                        n_err++;
                        $display("FAIL grant got addr=%h we=%b be=%b din=%h busy=%b want addr=%h we=%b be=%b din=%h busy=1",
                                 mem_addr, mem_we, mem_be, mem_din, busy, e.addr, e.we, e.be, e.din);
                    end
                end
            end
        end
    end

    initial begin : cpu_mon
        logic        prev;
        logic [15:0] e;
        prev = 1'b0;
        forever begin
            @(negedge MCLK);
            if (!RESET_N) begin
                prev = cpu_ack;
            end else if (cpu_ack != prev) begin
                prev = cpu_ack;
                cpu_done_cyc = cyc;
                n_vec++;
                if (cq.size() == 0) begin
                    n_err++;
                    $display("FAIL cpu_ack_unexpected dout=%h", cpu_dout);
                end else begin
                    e = cq.pop_front();
                    if (cpu_dout !== e || cyc - ack_cyc != 1) begin
                        n_err++;
                        $display("FAIL cpu_done got dout=%h lag=%0d want dout=%h lag=1",
                                 cpu_dout, cyc - ack_cyc, e);
                    end
                end
            end
        end
    end

    initial begin : sv_mon
        logic        prev;
        logic [15:0] e;
        prev = 1'b0;
        forever begin
            @(negedge MCLK);
            if (!RESET_N) begin
                prev = sv_ack;
            end else if (sv_ack != prev) begin
                prev = sv_ack;
                n_vec++;
                if (sq.size() == 0) begin
                    n_err++;
                    $display("FAIL sv_ack_unexpected dout=%h", sv_dout);
                end else begin
                    e = sq.pop_front();
                    if (sv_dout !== e || cyc - ack_cyc != 1) begin
                        n_err++;
                        $display("FAIL sv_done got dout=%h lag=%0d want dout=%h lag=1",
                                 sv_dout, cyc - ack_cyc, e);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic prev, exp;
        int   n;

        rom[32'h000100] = 16'h4E71;
        rom[32'h000200] = 16'h6000;
        rom[32'h200010] = 16'hBEEF;
        for (int i = 0; i < 9; i++) rom[32'h300 + i] = 16'(32'h1000 + i);
        rom[32'h200020] = 16'h5A5A;
        rom[32'h200022] = 16'hC3C3;
        rom[32'h200000] = 16'h1122;
        rom[32'h000104] = 16'h0F0F;
        rom[32'h200024] = 16'h3C3C;
        rom[32'h000102] = 16'h7777;

        #1 RESET_N = 1'b0;
        #10 reset_check("rst0");
        @(posedge MCLK);
        #2 RESET_N = 1'b1;

        // Single CPU read, 5-cycle memory
        lat = 5;
        @(negedge MCLK);
        push_g(24'h000100, 1'b0, 2'b11, 16'h0);
        cq.push_back(16'h4E71);
        cpu_addr = 24'h000100;
        cpu_req = ~cpu_req;
        wait_done(1);
        repeat (5) @(negedge MCLK);
        chk("t1_ack_once", {31'd0, cpu_ack}, {31'd0, cpu_req});

        // Download locks out CPU and save
        lat = 2;
        @(negedge MCLK);
        LOADING = 1'b1;
        push_g(24'h000000, 1'b1, 2'b11, 16'h1234);
        push_g(24'h000200, 1'b0, 2'b11, 16'h0);
        push_g(24'h200010, 1'b0, 2'b11, 16'h0);
        cq.push_back(16'h6000);
        sq.push_back(16'hBEEF);
        ld_addr = 24'h000000; ld_din = 16'h1234; ld_req = ~ld_req;
        cpu_addr = 24'h000200; cpu_req = ~cpu_req;
        sv_addr = 24'h200010; sv_we = 1'b0; sv_be = 2'b01; sv_req = ~sv_req;
        wait_done(0);
        repeat (10) @(negedge MCLK);
        chk("t2_hold_busy", {31'd0, busy}, 32'd0);
        chk("t2_hold_cpu_pending", {31'd0, cpu_ack != cpu_req}, 32'd1);
        prev = mem_req;
        LOADING = 1'b0;
        @(negedge MCLK);
        exp = ~prev;
        chk("t2_cpu_first_idle", {31'd0, mem_req}, {31'd0, exp});
        wait_done(1);
        wait_done(2);

        // Loader data reached memory
        @(negedge MCLK);
        push_g(24'h000000, 1'b0, 2'b11, 16'h0);
        cq.push_back(16'h1234);
        cpu_addr = 24'h000000; cpu_req = ~cpu_req;
        wait_done(1);

        // Starvation: CPUx4, SV, CPUx4, SV, CPU
        @(negedge MCLK);
        for (int i = 0; i < 4; i++) push_g(24'(32'h300 + i), 1'b0, 2'b11, 16'h0);
        push_g(24'h200020, 1'b0, 2'b11, 16'h0);
        for (int i = 4; i < 8; i++) push_g(24'(32'h300 + i), 1'b0, 2'b11, 16'h0);
        push_g(24'h200022, 1'b0, 2'b11, 16'h0);
        push_g(24'h000308, 1'b0, 2'b11, 16'h0);
        for (int i = 0; i < 9; i++) cq.push_back(16'(32'h1000 + i));
        sq.push_back(16'h5A5A);
        sq.push_back(16'hC3C3);
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    cpu_addr = 24'(32'h300 + i);
                    cpu_req = ~cpu_req;
                    wait_done(1);
                end
            end
            begin
                sv_we = 1'b0;
                sv_addr = 24'h200020; sv_req = ~sv_req;
                wait_done(2);
                sv_addr = 24'h200022; sv_req = ~sv_req;
                wait_done(2);
            end
        join

        // Save byte write then readback
        @(negedge MCLK);
        push_g(24'h200000, 1'b1, 2'b10, 16'hAB00);
        sq.push_back(16'hC3C3);
        sv_addr = 24'h200000; sv_we = 1'b1; sv_be = 2'b10; sv_din = 16'hAB00;
        sv_req = ~sv_req;
        wait_done(2);
        @(negedge MCLK);
        push_g(24'h200000, 1'b0, 2'b11, 16'h0);
        sq.push_back(16'hAB22);
        sv_we = 1'b0;
        sv_req = ~sv_req;
        wait_done(2);

        // Simultaneous CPU and save with counter at zero
        lat = 3;
        @(negedge MCLK);
        push_g(24'h000104, 1'b0, 2'b11, 16'h0);
        push_g(24'h200024, 1'b0, 2'b11, 16'h0);
        cq.push_back(16'h0F0F);
        sq.push_back(16'h3C3C);
        cpu_addr = 24'h000104; cpu_req = ~cpu_req;
        sv_addr = 24'h200024; sv_req = ~sv_req;
        fork
            wait_done(1);
            wait_done(2);
        join
        chk("t5_idle_gap", grant_cyc, cpu_done_cyc + 1);

        // Reset in the middle of a long read
        lat = 20;
        @(negedge MCLK);
        push_g(24'h000100, 1'b0, 2'b11, 16'h0);
        cpu_addr = 24'h000100; cpu_req = ~cpu_req;
        n = 0;
        while (!busy && n < 50) begin
            @(negedge MCLK);
            n++;
        end
        chk("t6_busy", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge MCLK);
        #3;
        RESET_N = 1'b0;
        rst_epoch++;
        cpu_req = 1'b0; ld_req = 1'b0; sv_req = 1'b0; mem_ack = 1'b0;
        #1 reset_check("rst1");
        repeat (3) @(posedge MCLK);
        #2 RESET_N = 1'b1;
        lat = 2;
        @(negedge MCLK);
        push_g(24'h000102, 1'b0, 2'b11, 16'h0);
        cq.push_back(16'h7777);
        cpu_addr = 24'h000102; cpu_req = ~cpu_req;
        wait_done(1);

        repeat (5) @(negedge MCLK);
        chk("grant_q_empty", gq.size(), 32'd0);
        chk("cpu_q_empty", cq.size(), 32'd0);
        chk("sv_q_empty", sq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
